gpio_irq: RTL and testbench
===========================

# gpio_irq

Interrupt and input-filter stage downstream of the GPIO port block. It consumes the 32-bit input vector that the GPIO block has already double-flop synchronised and glitch-filters each bit against a programmable sample rate. It detects rising and falling edges per bit, latches them into sticky write-1-to-clear status bits, and drives the 4-bit interrupt vector that the GPIO block currently ties to zero. It has its own small register window on the same byte-lane-enabled peripheral bus as the GPIO block.

## Interface
Parameters: none.

Ports:
- i_clk  in  1  system clock; all logic on rising edge
- i_rst  in  1  synchronous, active-high reset
- i_addr  in  3  register select
- i_din  in  32  write data
- i_wr_en  in  4  byte-lane write enables; lane n covers i_din[8n+7:8n]
- o_dout  out  32  registered read data for i_addr
- i_gpio_in  in  32  synchronised GPIO input vector from the GPIO block
- o_irq  out  4  registered interrupt lines; o_irq[k] covers GPIO bits 8k+7:8k

## Operation
- Register map, all 32 bits with byte-lane writes:
  - 0 IRQ_EN: per-bit enable.
  - 1 RISE_EN: per-bit rising-edge enable.
  - 2 FALL_EN: per-bit falling-edge enable.
  - 3 STATUS: sticky; a write of 1 clears that bit, a write of 0 has no effect.
  - 4 FILTER: bits 15:0 hold the prescale value; bits 31:16 read 0 and ignore writes.
  - 5 FILT_VAL: filtered input; read-only.
  - 6 and 7: read 0; writes ignored.
- Reset: all registers are 0, the prescale counter is 0, the per-bit stability counters are 0, the init flag is 1, and o_dout and o_irq are 0.
- Init: on the first cycle with init=1 and i_rst=0:
  - FILT_VAL loads i_gpio_in directly.
  - No edges are generated.
  - init clears.
  - This prevents a spurious edge on the first cycle out of reset.
- Prescaler: a 16-bit counter.
  - When counter == FILTER[15:0], tick=1 and the counter returns to 0; otherwise it increments.
  - FILTER=0 gives a tick every cycle.
  - Any write to FILTER (lanes 0/1) resets the counter to 0 in the same cycle.
- Per-bit filter: a 2-bit stability counter, evaluated only on tick cycles.
  - If i_gpio_in[i] == FILT_VAL[i], the counter clears.
  - Otherwise, if the counter == 2, FILT_VAL[i] toggles and the counter clears; otherwise the counter increments.
  - A change is therefore accepted after 3 consecutive differing ticks.
- Edge event: event[i] fires when FILT_VAL[i] toggles and IRQ_EN[i] is set and:
  - the toggle is 0->1 and RISE_EN[i] is set, or
  - the toggle is 1->0 and FALL_EN[i] is set.
- STATUS[i] is set on the same clock edge that FILT_VAL[i] toggles.
- If an event and a write-1-clear hit the same bit in the same cycle, set wins.
- o_irq[k] <= |STATUS[8k+7:8k].
- Clearing IRQ_EN does not clear STATUS.

## Timing
- Writes take effect on the clock edge at which i_wr_en is asserted.
- o_dout <= selected register every cycle, so read data is valid one cycle after i_addr. A read of STATUS in the same cycle as a write returns the pre-write value.
- With FILTER=0 and an input change first presented before edge E1:
  - FILT_VAL and STATUS update at E3.
  - o_irq asserts at E4.
- With FILTER=F, ticks are F+1 cycles apart, so acceptance takes 3 ticks.
- Pulses shorter than 3 ticks are rejected; the stability counter clears on the first matching tick.
- After a W1C, o_irq deasserts one edge after STATUS clears, unless another bit in the group is still set.
- A i_rst assertion mid-filter or mid-interrupt returns everything to its reset state at the next edge, including init=1.

## Test plan
- Reset and init: hold i_gpio_in=32'hA5A5_0F0F through reset, then release with IRQ_EN=RISE_EN=FALL_EN=all ones. Required: FILT_VAL reads 32'hA5A5_0F0F, STATUS stays 0, and o_irq=0.
- Rising edge, FILTER=0: enable bit 9 for rising edges, then drive bit 9 from 0 to 1. Required: STATUS=32'h0000_0200 at E3, o_irq=4'b0010 at E4. Then write STATUS=32'h0000_0200. Required: o_irq=0 two edges later.
- Glitch rejection: set FILTER=3 and pulse bit 0 high for 8 cycles (2 ticks). Required: FILT_VAL[0] and STATUS[0] stay 0. Then hold bit 0 high for 12 cycles. Required: FILT_VAL[0]=1 on the 3rd tick.
- Edge selection: enable RISE_EN only on bit 31, then toggle bit 31 up and down. Required: a single STATUS[31] set and o_irq=4'b1000. A falling edge on bit 31 with FALL_EN=0 leaves STATUS unchanged after a clear.
- Set/clear collision: schedule a W1C of bit 4 on the same cycle that bit 4's filtered value toggles. Required: STATUS[4] remains 1.
- Byte lanes and reset mid-operation: write FILTER=32'hFFFF_1234 with i_wr_en=4'b0001. Required: FILTER reads 32'h0000_0034. Then assert i_rst while o_irq is nonzero. Required: all registers, o_dout and o_irq read 0 after one edge.

Source files
------------

// File: rtl/gpio_irq.sv
// gpio_irq: per-bit glitch filter, edge detector, sticky W1C interrupt
// status and grouped interrupt lines for the 32-bit GPIO input vector.
//
// Bus handshake: there is no valid/ready pair on this window. A write is
// accepted on every rising clock edge at which any bit of i_wr_en is set for
// the addressed register. Read data for i_addr is registered, so it appears
// on o_dout one edge after i_addr is presented, with no back-pressure.
module gpio_irq (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [2:0]  i_addr,
  input  logic [31:0] i_din,
  input  logic [3:0]  i_wr_en,
  output logic [31:0] o_dout,
  input  logic [31:0] i_gpio_in,
  output logic [3:0]  o_irq
);

  localparam logic [2:0] ADDR_IRQ_EN   = 3'd0;
  localparam logic [2:0] ADDR_RISE_EN  = 3'd1;
  localparam logic [2:0] ADDR_FALL_EN  = 3'd2;
  localparam logic [2:0] ADDR_STATUS   = 3'd3;
  localparam logic [2:0] ADDR_FILTER   = 3'd4;
  localparam logic [2:0] ADDR_FILT_VAL = 3'd5;

  // Register state
  logic [31:0]       irq_en_q,   irq_en_d;
  logic [31:0]       rise_en_q,  rise_en_d;
  logic [31:0]       fall_en_q,  fall_en_d;
  logic [31:0]       status_q,   status_d;
  logic [15:0]       filter_q,   filter_d;
  logic [31:0]       filt_val_q, filt_val_d;
  logic [15:0]       presc_q,    presc_d;
  logic [31:0][1:0]  stab_q,     stab_d;
  logic              init_q;
  logic [31:0]       dout_q,     dout_d;
  logic [3:0]        irq_q,      irq_d;

  // Combinational helpers
  logic [31:0] lane_mask;
  logic        filter_wr;
  logic        tick;
  logic [31:0] toggle;
  logic [31:0] edge_event;
  logic [31:0] w1c_mask;

  // Expand the byte-lane enables into a per-bit write mask
  always_comb begin
    lane_mask = '0;
    for (int n = 0; n < 4; n++) begin
      lane_mask[8*n +: 8] = {8{i_wr_en[n]}};
    end
  end

  // Configuration register writes, merged byte lane by byte lane
  always_comb begin
    irq_en_d  = irq_en_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    filter_d  = filter_q;
    filter_wr = 1'b0;
    w1c_mask  = '0;
    case (i_addr)
      ADDR_IRQ_EN:  irq_en_d  = (irq_en_q  & ~lane_mask) | (i_din & lane_mask);
      ADDR_RISE_EN: rise_en_d = (rise_en_q & ~lane_mask) | (i_din & lane_mask);
      ADDR_FALL_EN: fall_en_d = (fall_en_q & ~lane_mask) | (i_din & lane_mask);
      ADDR_STATUS:  w1c_mask  = i_din & lane_mask;
      ADDR_FILTER: begin
        // FILTER holds a 16-bit prescale value; lanes 2/3 are read-as-zero.
        filter_d  = (filter_q & ~lane_mask[15:0]) | (i_din[15:0] & lane_mask[15:0]);
        filter_wr = i_wr_en[0] | i_wr_en[1];
      end
      default: ;
    endcase
  end

  // Prescaler: one tick each FILTER+1 cycles, restarted by a FILTER write
  always_comb begin
    tick    = (presc_q == filter_q);
    presc_d = presc_q + 16'd1;
    if (filter_wr || tick) begin
      presc_d = '0;
    end
  end

  // Per-bit stability filter; first cycle after reset just captures the input
  always_comb begin
    filt_val_d = filt_val_q;
    stab_d     = stab_q;
    toggle     = '0;
    if (init_q) begin
      filt_val_d = i_gpio_in;
    end else if (tick) begin
      for (int i = 0; i < 32; i++) begin
        if (i_gpio_in[i] == filt_val_q[i]) begin
          stab_d[i] = 2'd0;
        end else if (stab_q[i] == 2'd2) begin
          toggle[i]     = 1'b1;
          filt_val_d[i] = ~filt_val_q[i];
          stab_d[i]     = 2'd0;
        end else begin
          stab_d[i] = stab_q[i] + 2'd1;
        end
      end
    end
  end

  // Edge qualification and sticky status; a new event beats a same-cycle clear
  always_comb begin
    edge_event = toggle & irq_en_q &
                 ((~filt_val_q & rise_en_q) | (filt_val_q & fall_en_q));
    status_d   = (status_q & ~w1c_mask) | edge_event;
  end

  // Interrupt grouping and read-data mux, both registered
  always_comb begin
    irq_d = '0;
    for (int k = 0; k < 4; k++) begin
      irq_d[k] = |status_q[8*k +: 8];
    end
    dout_d = '0;
    case (i_addr)
      ADDR_IRQ_EN:   dout_d = irq_en_q;
      ADDR_RISE_EN:  dout_d = rise_en_q;
      ADDR_FALL_EN:  dout_d = fall_en_q;
      ADDR_STATUS:   dout_d = status_q;
      ADDR_FILTER:   dout_d = {16'h0000, filter_q};
      ADDR_FILT_VAL: dout_d = filt_val_q;
      default:       dout_d = '0;
    endcase
  end

  // State registers with synchronous reset
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      irq_en_q   <= '0;
      rise_en_q  <= '0;
      fall_en_q  <= '0;
      status_q   <= '0;
      filter_q   <= '0;
      filt_val_q <= '0;
      presc_q    <= '0;
      stab_q     <= '0;
      init_q     <= 1'b1;
      dout_q     <= '0;
      irq_q      <= '0;
    end else begin
      irq_en_q   <= irq_en_d;
      rise_en_q  <= rise_en_d;
      fall_en_q  <= fall_en_d;
      status_q   <= status_d;
      filter_q   <= filter_d;
      filt_val_q <= filt_val_d;
      presc_q    <= presc_d;
      stab_q     <= stab_d;
      init_q     <= 1'b0;
      dout_q     <= dout_d;
      irq_q      <= irq_d;
    end
  end

  assign o_dout = dout_q;
  assign o_irq  = irq_q;

endmodule

// File: tb/tb_gpio_irq.sv
// Directed testbench for gpio_irq: reset/init, filter timing, glitch
// rejection, edge selection, set/clear collision, byte lanes, mid-run reset.
module tb_gpio_irq;

  localparam logic [2:0] A_IRQ_EN   = 3'd0;
  localparam logic [2:0] A_RISE_EN  = 3'd1;
  localparam logic [2:0] A_FALL_EN  = 3'd2;
  localparam logic [2:0] A_STATUS   = 3'd3;
  localparam logic [2:0] A_FILTER   = 3'd4;
  localparam logic [2:0] A_FILT_VAL = 3'd5;

  logic        i_clk;
  logic        i_rst;
  logic [2:0]  i_addr;
  logic [31:0] i_din;
  logic [3:0]  i_wr_en;
  logic [31:0] o_dout;
  logic [31:0] i_gpio_in;
  logic [3:0]  o_irq;

  int n_cmp;
  int n_err;
  logic [31:0] rd;

  gpio_irq dut (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_addr    (i_addr),
    .i_din     (i_din),
    .i_wr_en   (i_wr_en),
    .o_dout    (o_dout),
    .i_gpio_in (i_gpio_in),
    .o_irq     (o_irq)
  );

  // Clock
  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  // Compare helper
  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h", tag, act, exp);
    end
  endtask

  // Advance n edges, landing 1 time unit after the last one
  task automatic step(input int n);
    repeat (n) @(posedge i_clk);
    #1;
  endtask

  task automatic write_reg(input logic [2:0] a, input logic [31:0] d, input logic [3:0] en);
    i_addr  = a;
    i_din   = d;
    i_wr_en = en;
    step(1);
    i_wr_en = 4'h0;
  endtask

  task automatic read_reg(input logic [2:0] a, output logic [31:0] d);
    i_addr = a;
    step(1);
    d = o_dout;
  endtask

  initial begin
    n_cmp     = 0;
    n_err     = 0;
    i_rst     = 1'b1;
    i_addr    = 3'd0;
    i_din     = '0;
    i_wr_en   = 4'h0;
    i_gpio_in = 32'hA5A5_0F0F;

    // Reset and init
    step(3);
    check_eq("rst_irq", {28'h0, o_irq}, 32'h0);
    check_eq("rst_dout", o_dout, 32'h0);
    i_rst = 1'b0;
    write_reg(A_IRQ_EN,  32'hFFFF_FFFF, 4'hF);
    write_reg(A_RISE_EN, 32'hFFFF_FFFF, 4'hF);
    write_reg(A_FALL_EN, 32'hFFFF_FFFF, 4'hF);
    read_reg(A_FILT_VAL, rd);
    check_eq("init_filt_val", rd, 32'hA5A5_0F0F);
    read_reg(A_STATUS, rd);
    check_eq("init_status", rd, 32'h0);
    check_eq("init_irq", {28'h0, o_irq}, 32'h0);

    // Settle inputs to zero with interrupts masked: no status
    write_reg(A_IRQ_EN, 32'h0, 4'hF);
    i_gpio_in = 32'h0;
    step(6);
    read_reg(A_FILT_VAL, rd);
    check_eq("masked_filt_val", rd, 32'h0);
    read_reg(A_STATUS, rd);
    check_eq("masked_status", rd, 32'h0);

    // Rising edge on bit 9 with FILTER=0
    write_reg(A_FALL_EN, 32'h0, 4'hF);
    write_reg(A_IRQ_EN, 32'h0000_0200, 4'hF);
    i_addr = A_STATUS;
    i_gpio_in[9] = 1'b1;
    step(3);  // E3: read data still shows the pre-E3 status
    check_eq("rise_e3_status", o_dout, 32'h0);
    check_eq("rise_e3_irq", {28'h0, o_irq}, 32'h0);
    step(1);  // E4
    check_eq("rise_e4_status", o_dout, 32'h0000_0200);
    check_eq("rise_e4_irq", {28'h0, o_irq}, 32'h2);
    write_reg(A_STATUS, 32'h0000_0200, 4'hF);
    check_eq("w1c_pre_read", o_dout, 32'h0000_0200);
    check_eq("w1c_irq_still", {28'h0, o_irq}, 32'h2);
    step(1);
    check_eq("w1c_irq_clear", {28'h0, o_irq}, 32'h0);
    check_eq("w1c_status", o_dout, 32'h0);

    // Glitch rejection with FILTER=3 (tick every 4 cycles)
    write_reg(A_IRQ_EN,  32'hFFFF_FFFF, 4'hF);
    write_reg(A_RISE_EN, 32'hFFFF_FFFF, 4'hF);
    write_reg(A_FILTER,  32'h0000_0003, 4'hF);  // counter restarts here
    i_addr = A_FILT_VAL;
    i_gpio_in[0] = 1'b1;
    step(8);
    i_gpio_in[0] = 1'b0;
    step(4);
    check_eq("glitch_filt_val", o_dout, 32'h0000_0200);
    check_eq("glitch_irq", {28'h0, o_irq}, 32'h0);
    i_gpio_in[0] = 1'b1;
    step(12);
    check_eq("hold_before_3rd", o_dout, 32'h0000_0200);
    step(1);
    check_eq("hold_after_3rd", o_dout, 32'h0000_0201);
    check_eq("hold_irq", {28'h0, o_irq}, 32'h1);
    write_reg(A_FILTER, 32'h0, 4'hF);
    write_reg(A_STATUS, 32'hFFFF_FFFF, 4'hF);
    read_reg(A_STATUS, rd);
    check_eq("cleanup_status", rd, 32'h0);

    // Edge selection on bit 31: rising only
    write_reg(A_RISE_EN, 32'h8000_0000, 4'hF);
    i_gpio_in[31] = 1'b1;
    step(4);
    read_reg(A_STATUS, rd);
    check_eq("b31_rise_status", rd, 32'h8000_0000);
    check_eq("b31_rise_irq", {28'h0, o_irq}, 32'h8);
    write_reg(A_STATUS, 32'h8000_0000, 4'hF);
    i_gpio_in[31] = 1'b0;
    step(5);
    read_reg(A_STATUS, rd);
    check_eq("b31_fall_status", rd, 32'h0);
    check_eq("b31_fall_irq", {28'h0, o_irq}, 32'h0);
    read_reg(A_FILT_VAL, rd);
    check_eq("b31_fall_filt", rd, 32'h0000_0201);

    // Set/clear collision on bit 4
    write_reg(A_RISE_EN, 32'h0000_0010, 4'hF);
    i_gpio_in[4] = 1'b1;
    step(2);
    i_addr  = A_STATUS;
    i_din   = 32'h0000_0010;
    i_wr_en = 4'hF;
    step(1);  // E3: toggle and W1C together
    i_wr_en = 4'h0;
    step(1);
    check_eq("collide_status", o_dout, 32'h0000_0010);
    check_eq("collide_irq", {28'h0, o_irq}, 32'h1);

    // Byte lanes
    write_reg(A_FILTER, 32'hFFFF_1234, 4'b0001);
    read_reg(A_FILTER, rd);
    check_eq("filter_lane0", rd, 32'h0000_0034);
    write_reg(A_IRQ_EN, 32'h0, 4'b0100);
    read_reg(A_IRQ_EN, rd);
    check_eq("irq_en_lane2", rd, 32'hFF00_FFFF);
    write_reg(3'd6, 32'hFFFF_FFFF, 4'hF);
    read_reg(3'd6, rd);
    check_eq("addr6_read", rd, 32'h0);
    i_addr = A_STATUS;
    step(1);
    check_eq("pre_rst_irq", {28'h0, o_irq}, 32'h1);

    // Reset mid-operation
    i_rst = 1'b1;
    step(1);
    check_eq("midrst_irq", {28'h0, o_irq}, 32'h0);
    check_eq("midrst_dout", o_dout, 32'h0);
    i_rst = 1'b0;
    read_reg(A_IRQ_EN, rd);
    check_eq("midrst_irq_en", rd, 32'h0);
    read_reg(A_STATUS, rd);
    check_eq("midrst_status", rd, 32'h0);
    read_reg(A_FILTER, rd);
    check_eq("midrst_filter", rd, 32'h0);
    read_reg(A_RISE_EN, rd);
    check_eq("midrst_rise_en", rd, 32'h0);
    read_reg(A_FILT_VAL, rd);
    check_eq("midrst_filt_val", rd, 32'h0000_0211);
    check_eq("midrst_irq_after", {28'h0, o_irq}, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
